lcd_time_message: RTL and testbench
===================================

Name: lcd_time_message

Overview:
- Parametrised 2-line character-buffer generator for the HD44780-style LCD driver.
- Converts a binary seconds count into an ASCII "MM:SS" field using a sequential subtract-based converter.
- Shows a mode label on line 1 and can blink the colon.
- The LCD driver reads the buffer through an asynchronous read port; digit and label writes commit atomically in one cycle, so no torn values are ever displayed.

Parameters:
- T_WIDTH, 13: width of the seconds input.
- COLS, 16: characters per line; must be at least TIME_COL+5 and at least 6.
- TIME_COL, 2: column of the first minute digit on line 2.
- BLINK_HALF, 25_000_000: colon blink half-period in clk cycles; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- t  in  T_WIDTH  elapsed or remaining seconds.
- mode  in  2  label select: 0 "TIME:", 1 "LEFT:", 2 "DONE!", 3 "PAUSE".
- t_valid  in  1  update request, qualified by ready.
- ready  out  1  converter idle and able to accept a request.
- blink_en  in  1  colon blinks when 1; steady ':' when 0.
- raddr  in  $clog2(2*COLS)  character address; line 1 is 0..COLS-1, line 2 is COLS..2*COLS-1.
- dout  out  8  ASCII character at raddr (combinational read).
- updated  out  1  one-cycle pulse when a new image has been committed.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - State is IDLE; ready=1; updated=0.
  - Blink counter cleared; colon phase is "on".
  - Buffer holds the reset image: line 1 "TIME:" padded with spaces (0x20); line 2 spaces with "00:00" at TIME_COL..TIME_COL+4.
- Handshake:
  - A request is accepted on a rising edge where t_valid=1 and ready=1.
  - The accept edge latches t into rem and mode into mode_q, and enters DIV60.
  - ready stays 0 from the accept edge until the state returns to IDLE.
  - t_valid while ready=0 is ignored; requests are not queued.
- FSM: IDLE -> DIV60 -> SEC10 -> MIN10 -> COMMIT -> IDLE.
  - DIV60: each cycle, if rem>=60 then rem-=60 and min++; otherwise go to SEC10. On exit, if min>99 then force min=99 and rem=59 (saturation).
  - SEC10: each cycle, if rem>=10 then rem-=10 and stens++; otherwise go to MIN10. sones=rem.
  - MIN10: same procedure on min, producing mtens and mones.
  - COMMIT: on one edge, write four digits (0x30+digit) and the 5-character label into the buffer, pulse updated for one cycle, and return to IDLE with ready=1.
- Latency:
  - Let q60 = min(t/60, 99), qs = sec/10, qm = min/10 (saturated values).
  - The buffer and updated change q60+qs+qm+4 edges after the accept edge.
  - The next request can be accepted on the following edge.
- Colon at TIME_COL+2:
  - Free-running counter wraps at BLINK_HALF-1 and toggles the phase on wrap.
  - With blink_en=1, dout shows ':' in the on phase and ' ' in the off phase.
  - With blink_en=0, dout always shows ':'.
  - The colon is generated at read time, not stored.
- Read port:
  - dout = buffer[raddr], with no register.
  - raddr >= 2*COLS returns 0x20.
- Reset during a conversion aborts it; the buffer returns to the reset image and no updated pulse is produced.
- Minute counter width is 7 bits; rem is T_WIDTH bits. Arithmetic is unsigned with no wrap because of the saturation rule.

Decomposition:
- Package lcd_msg_pkg holds:
  - The state enum (IDLE, DIV60, SEC10, MIN10, COMMIT).
  - ASCII constants (SPACE, COLON, ZERO).
  - The 4x5 label ROM.
  - A function for the raddr width.
- Sub-module lcd_bin2mmss holds the converter FSM: t/t_valid/ready in, four BCD digits plus a done pulse out.
- The top level holds the buffer, label write, blink counter and read mux.

Test Plan:
- Reset, then read all 32 addresses -> "TIME:" plus 11 spaces; line 2 "  00:00" plus 9 spaces; ready=1; updated=0.
- t=125, mode=0 -> updated exactly 6 edges after accept; line 2 reads "  02:05"; ready is low for 6 cycles.
- t=8191, mode=1 (saturation) -> line 1 "LEFT:", line 2 "  99:59"; latency 99+5+9+4 = 117 edges.
- t_valid held high with values 59 then 60 -> the second value is ignored while busy; the next accept shows "01:00" after 5 edges.
- blink_en=1, BLINK_HALF=4 -> raddr=20 alternates ':' / ' ' every 4 cycles; with blink_en=0 it is constant ':'.
- rst_n pulsed low mid-DIV60 after t=3000 -> no updated pulse; buffer shows the reset image; ready=1 immediately.

Source files
------------

// File: rtl/lcd_msg_pkg.sv
// Shared types and constants for the LCD time-message generator:
// converter states, ASCII codes and the mode label ROM.
package lcd_msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIV60,
        SEC10,
        MIN10,
        COMMIT
    } state_t;

    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [6:0] MIN_MAX = 7'd99;

    // Five-character label per mode, first character in the top byte.
    function automatic logic [39:0] label_str(input logic [1:0] m);
        logic [39:0] s;
        case (m)
            2'd0:    s = "TIME:";
            2'd1:    s = "LEFT:";
            2'd2:    s = "DONE!";
            default: s = "PAUSE";
        endcase
        return s;
    endfunction

    function automatic logic [7:0] label_char(input logic [1:0] m, input int k);
        logic [39:0] s;
        s = label_str(m);
        return s[8*(4-k) +: 8];
    endfunction

    function automatic int addr_w(input int cols);
        return $clog2(2*cols);
    endfunction

endpackage

// File: rtl/lcd_time_message_if.sv
// Request/readback bus between the timer logic / LCD driver and the
// character-buffer generator.
interface lcd_time_message_if
    import lcd_msg_pkg::*;
#(
    parameter int T_WIDTH = 13,
    parameter int COLS    = 16
);
    localparam int AW = addr_w(COLS);

    logic [T_WIDTH-1:0] t;
    logic [1:0]         mode;
    logic               t_valid;
    logic               ready;
    logic               blink_en;
    logic [AW-1:0]      raddr;
    logic [7:0]         dout;
    logic               updated;

    modport master (
        output t, mode, t_valid, blink_en, raddr,
        input  ready, dout, updated
    );

    modport slave (
        input  t, mode, t_valid, blink_en, raddr,
        output ready, dout, updated
    );

endinterface

// File: rtl/lcd_bin2mmss.sv
// Sequential seconds -> MM:SS converter using repeated subtraction,
// with minutes saturated at 99:59.
module lcd_bin2mmss
    import lcd_msg_pkg::*;
#(
    parameter int T_WIDTH = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [T_WIDTH-1:0] t,
    input  logic               t_valid,
    output logic               ready,
    output logic [3:0]         mtens,
    output logic [3:0]         mones,
    output logic [3:0]         stens,
    output logic [3:0]         sones,
    output logic               done
);

    localparam logic [T_WIDTH-1:0] C60 = T_WIDTH'(60);
    localparam logic [T_WIDTH-1:0] C59 = T_WIDTH'(59);
    localparam logic [T_WIDTH-1:0] C10 = T_WIDTH'(10);

    state_t             state, state_nxt;
    logic [T_WIDTH-1:0] rem, rem_nxt;
    logic [6:0]         min_q, min_nxt;
    logic [3:0]         stens_q, stens_nxt;
    logic [3:0]         mtens_q, mtens_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Working registers are only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        rem     <= rem_nxt;
        min_q   <= min_nxt;
        stens_q <= stens_nxt;
        mtens_q <= mtens_nxt;
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        min_nxt   = min_q;
        stens_nxt = stens_q;
        mtens_nxt = mtens_q;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (t_valid) begin
                    rem_nxt   = t;
                    min_nxt   = 7'd0;
                    stens_nxt = 4'd0;
                    mtens_nxt = 4'd0;
                    state_nxt = DIV60;
                end
            end
            DIV60: begin
                // Stop counting at 99 so the 7-bit minute counter never wraps.
                if (rem >= C60 && min_q < MIN_MAX) begin
                    rem_nxt = rem - C60;
                    min_nxt = min_q + 7'd1;
                end else begin
                    state_nxt = SEC10;
                    if (rem >= C60) rem_nxt = C59;
                end
            end
            SEC10: begin
                if (rem >= C10) begin
                    rem_nxt   = rem - C10;
                    stens_nxt = stens_q + 4'd1;
                end else begin
                    state_nxt = MIN10;
                end
            end
            MIN10: begin
                if (min_q >= 7'd10) begin
                    min_nxt   = min_q - 7'd10;
                    mtens_nxt = mtens_q + 4'd1;
                end else begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mtens = mtens_q;
    assign mones = min_q[3:0];
    assign stens = stens_q;
    assign sones = rem[3:0];

endmodule

// File: rtl/lcd_time_message.sv
// Two-line LCD character buffer: mode label on line 1, MM:SS on line 2,
// with a read-time blinking colon and an unregistered read port.
module lcd_time_message
    import lcd_msg_pkg::*;
#(
    parameter int T_WIDTH    = 13,
    parameter int COLS       = 16,
    parameter int TIME_COL   = 2,
    parameter int BLINK_HALF = 25_000_000
) (
    input logic               clk,
    input logic               rst_n,
    lcd_time_message_if.slave bus
);

    localparam int NCHAR      = 2*COLS;
    localparam int TBASE      = COLS + TIME_COL;
    localparam int COLON_ADDR = TBASE + 2;
    localparam int CNT_W      = $clog2(BLINK_HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [7:0]       buf_q [NCHAR];
    logic [1:0]       mode_q;
    logic [3:0]       mtens, mones, stens, sones;
    logic             done;
    logic [CNT_W-1:0] blink_cnt;
    logic             phase_on;

    function automatic logic [7:0] reset_char(input int i);
        logic [7:0] c;
        c = SPACE;
        if (i < 5)                                  c = label_char(2'd0, i);
        else if (i == COLON_ADDR)                   c = COLON;
        else if (i >= TBASE && i <= TBASE + 4)      c = ZERO;
        return c;
    endfunction

    lcd_bin2mmss #(.T_WIDTH(T_WIDTH)) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .t       (bus.t),
        .t_valid (bus.t_valid),
        .ready   (bus.ready),
        .mtens   (mtens),
        .mones   (mones),
        .stens   (stens),
        .sones   (sones),
        .done    (done)
    );

    always_ff @(posedge clk) begin
        if (bus.t_valid && bus.ready) mode_q <= bus.mode;
    end

    // Label and all four digits land on the same edge, so a reader never
    // sees a half-updated image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAR; i++) buf_q[i] <= reset_char(i);
        end else if (done) begin
            for (int k = 0; k < 5; k++) buf_q[k] <= label_char(mode_q, k);
            buf_q[TBASE]     <= ZERO + 8'(mtens);
            buf_q[TBASE + 1] <= ZERO + 8'(mones);
            buf_q[TBASE + 3] <= ZERO + 8'(stens);
            buf_q[TBASE + 4] <= ZERO + 8'(sones);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.updated <= 1'b0;
        else        bus.updated <= done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.dout = SPACE;
        if (int'(bus.raddr) < NCHAR) bus.dout = buf_q[bus.raddr];
        if (int'(bus.raddr) == COLON_ADDR)
            bus.dout = (!bus.blink_en || phase_on) ? COLON : SPACE;
    end

endmodule

// File: tb/tb_lcd_time_message.sv
// Testbench for lcd_time_message: vector table with a scoreboard queue,
// plus hand-written busy-ignore, blink and reset-abort sequences.
module tb_lcd_time_message;
    import lcd_msg_pkg::*;

    localparam int T_WIDTH = 13;
    localparam int COLS    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_time_message_if #(.T_WIDTH(T_WIDTH), .COLS(COLS)) bus ();

    lcd_time_message #(
        .T_WIDTH(T_WIDTH), .COLS(COLS), .TIME_COL(2), .BLINK_HALF(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          t;
        int          mode;
        logic [39:0] label;
        logic [39:0] mmss;
        int          lat;
    } vec_t;

    typedef struct {
        logic [39:0] label;
        logic [39:0] mmss;
    } exp_t;

    vec_t vecs[9];
    exp_t exp_q[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic read_line(input int base, output logic [127:0] s);
        for (int i = 0; i < 16; i++) begin
            bus.raddr = 5'(base + i);
            #1;
            s[8*(15-i) +: 8] = bus.dout;
        end
    endtask

    task automatic check_image(input string name, input logic [39:0] label, input logic [39:0] mmss);
        logic [127:0] l1, l2;
        read_line(0, l1);
        read_line(COLS, l2);
        check_eq({name, "_line1"}, l1, {label, {11{SPACE}}});
        check_eq({name, "_line2"}, l2, {{2{SPACE}}, mmss, {9{SPACE}}});
    endtask

    // Counts edges after the accept edge until updated rises; returns -1 on timeout.
    task automatic wait_updated(output int n, output bit busy_ok);
        bit got;
        n = 0; got = 0; busy_ok = 1;
        while (!got && n < 300) begin
            @(posedge clk); n++; #1;
            if (bus.updated) got = 1;
            else if (bus.ready) busy_ok = 0;
        end
        if (!got) n = -1;
    endtask

    task automatic score(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL %s_scoreboard: got updated pulse, required none pending", name);
        end else begin
            e = exp_q.pop_front();
            check_image(name, e.label, e.mmss);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n; bit busy_ok;
        @(negedge clk);
        check_eq({name, "_ready_pre"}, 128'(bus.ready), 128'(1));
        bus.t = T_WIDTH'(v.t); bus.mode = 2'(v.mode); bus.t_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{label: v.label, mmss: v.mmss});
        @(negedge clk);
        bus.t_valid = 1'b0;
        wait_updated(n, busy_ok);
        check_eq({name, "_latency"}, 128'(n), 128'(v.lat));
        check_eq({name, "_ready_busy"}, 128'(busy_ok), 128'(1));
        @(posedge clk); #1;
        check_eq({name, "_updated_fall"}, 128'(bus.updated), 128'(0));
        if (n < 0) void'(exp_q.pop_front());
        else       score(name);
    endtask

    initial begin
        int n; bit busy_ok;
        logic [7:0] smp[16];
        bit seen_on, seen_off;

        vecs[0] = '{125,  0, "TIME:", "02:05", 6};
        vecs[1] = '{8191, 1, "LEFT:", "99:59", 117};
        vecs[2] = '{0,    2, "DONE!", "00:00", 4};
        vecs[3] = '{5999, 3, "PAUSE", "99:59", 117};
        vecs[4] = '{6000, 0, "TIME:", "99:59", 117};
        vecs[5] = '{5940, 1, "LEFT:", "99:00", 112};
        vecs[6] = '{599,  2, "DONE!", "09:59", 18};
        vecs[7] = '{3599, 0, "TIME:", "59:59", 73};
        vecs[8] = '{61,   3, "PAUSE", "01:01", 5};

        bus.t = '0; bus.mode = 2'd0; bus.t_valid = 1'b0; bus.blink_en = 1'b0; bus.raddr = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_ready", 128'(bus.ready), 128'(1));
        check_eq("reset_updated", 128'(bus.updated), 128'(0));
        rst_n = 1'b1;
        check_image("reset", "TIME:", "00:00");

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // t_valid held high: second value waits until the first finishes.
        @(negedge clk);
        bus.t = 13'd59; bus.mode = 2'd0; bus.t_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{label: "TIME:", mmss: "00:59"});
        @(negedge clk);
        bus.t = 13'd60;
        wait_updated(n, busy_ok);
        check_eq("hold_first_latency", 128'(n), 128'(9));
        check_eq("hold_first_busy", 128'(busy_ok), 128'(1));
        @(posedge clk);
        exp_q.push_back('{label: "TIME:", mmss: "01:00"});
        #1;
        check_eq("hold_second_accept", 128'(bus.ready), 128'(0));
        @(negedge clk);
        bus.t_valid = 1'b0;
        score("hold_first");
        // score() reads over several edges; restart edge count from a known accept instead.
        wait_updated(n, busy_ok);
        check_eq("hold_second_seen", 128'(n >= 0), 128'(1));
        score("hold_second");

        // Second busy-ignore check with exact latency of the follow-up.
        @(negedge clk);
        bus.t = 13'd60; bus.t_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{label: "TIME:", mmss: "01:00"});
        @(negedge clk);
        bus.t = 13'd7000;
        wait_updated(n, busy_ok);
        bus.t_valid = 1'b0;
        check_eq("hold60_latency", 128'(n), 128'(5));
        score("hold60");

        // Blink: colon at address 20 alternates every 4 cycles.
        bus.blink_en = 1'b1;
        bus.raddr = 5'd20;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            smp[i] = bus.dout;
        end
        seen_on = 0; seen_off = 0;
        for (int i = 0; i < 16; i++) begin
            if (smp[i] == COLON) seen_on = 1;
            if (smp[i] == SPACE) seen_off = 1;
        end
        check_eq("blink_both_phases", 128'({seen_on, seen_off}), 128'(2'b11));
        for (int i = 4; i < 16; i++)
            check_eq($sformatf("blink_toggle%0d", i), 128'(smp[i] != smp[i-4]), 128'(1));
        bus.blink_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("steady_colon%0d", i), 128'(bus.dout), 128'(COLON));
        end

        // Reset mid-DIV60 aborts the conversion.
        run_vec(vecs[8], "pre_abort");
        @(negedge clk);
        bus.t = 13'd3000; bus.mode = 2'd1; bus.t_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.t_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_ready", 128'(bus.ready), 128'(1));
        check_eq("abort_updated", 128'(bus.updated), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bus.updated) n++;
        end
        check_eq("abort_no_pulse", 128'(n), 128'(0));
        check_image("abort", "TIME:", "00:00");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
